// File: rtl/alu_pipe.sv
// Handshaked, parametrised ALU with registered result/flags and an iterative
// radix-2 shift-add unsigned multiplier. Legacy opcodes 0-7 are unchanged.
module alu_pipe #(
  parameter int WIDTH      = 16,
  parameter int MUL_ENABLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic [3:0]       io_aluOp,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_result,
  output logic [WIDTH-1:0] io_result_hi,
  output logic             io_zero,
  output logic             io_carry,
  output logic             io_negative,
  output logic             io_overflow,
  output logic             io_illegal
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   resultHi_q, resultHi_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic               isMul;
  logic [WIDTH:0]     sumExt;
  logic [WIDTH:0]     diffExt;
  logic [WIDTH-1:0]   aluRes;
  logic [WIDTH-1:0]   flagRes;
  logic               aluCarry;
  logic               aluOvf;
  logic               aluIll;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] accNext;

  assign io_in_ready = (state_q == IDLE) || ((state_q == HOLD) && io_out_ready);
  assign accept      = io_in_valid && io_in_ready;
  assign isMul       = (MUL_ENABLE != 0) && (io_aluOp == 4'd10);

  assign sumExt  = {1'b0, io_a} + {1'b0, io_b};
  assign diffExt = {1'b0, io_a} - {1'b0, io_b};

  // Each multiply step adds the multiplicand into the high half when the current
  // multiplier bit is set, then shifts the whole accumulator right by one.
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplr_q[0] ? mcand_q : '0)};
  assign accNext = {mulSum, acc_q[WIDTH-1:1]};

  always_comb begin
    aluRes   = io_a;
    flagRes  = io_a;
    aluCarry = 1'b0;
    aluOvf   = 1'b0;
    aluIll   = 1'b0;
    case (io_aluOp)
      4'd0: aluRes = io_a;
      4'd1: begin
        aluRes   = sumExt[WIDTH-1:0];
        aluCarry = sumExt[WIDTH];
        aluOvf   = (io_a[WIDTH-1] == io_b[WIDTH-1]) && (sumExt[WIDTH-1] != io_a[WIDTH-1]);
      end
      4'd2: begin
        aluRes   = diffExt[WIDTH-1:0];
        aluCarry = diffExt[WIDTH];
        aluOvf   = (io_a[WIDTH-1] != io_b[WIDTH-1]) && (diffExt[WIDTH-1] != io_a[WIDTH-1]);
      end
      4'd3: aluRes = io_a & io_b;
      4'd4: aluRes = io_a | io_b;
      4'd5: aluRes = io_a ^ io_b;
      4'd6: aluRes = io_b;
      4'd7: begin
        aluRes   = {1'b0, io_a[WIDTH-1:1]};
        aluCarry = io_a[0];
      end
      4'd8: begin
        aluRes   = {io_a[WIDTH-2:0], 1'b0};
        aluCarry = io_a[WIDTH-1];
      end
      4'd9: begin
        aluRes   = {io_a[WIDTH-1], io_a[WIDTH-1:1]};
        aluCarry = io_a[0];
      end
      4'd10: aluIll = (MUL_ENABLE == 0);
      4'd11: begin
        aluCarry = diffExt[WIDTH];
        aluOvf   = (io_a[WIDTH-1] != io_b[WIDTH-1]) && (diffExt[WIDTH-1] != io_a[WIDTH-1]);
      end
      default: aluIll = 1'b1;
    endcase
    // Compare keeps a as its result but reports zero/negative of the difference.
    flagRes = (io_aluOp == 4'd11) ? diffExt[WIDTH-1:0] : aluRes;
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    result_d   = result_q;
    resultHi_d = resultHi_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    ill_d      = ill_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplr_d     = mplr_q;
    cnt_d      = cnt_q;
    case (state_q)
      MUL: begin
        acc_d  = accNext;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d   = accNext[WIDTH-1:0];
          resultHi_d = accNext[2*WIDTH-1:WIDTH];
          zero_d     = (accNext == '0);
          carry_d    = |accNext[2*WIDTH-1:WIDTH];
          neg_d      = accNext[WIDTH-1];
          ovf_d      = 1'b0;
          ill_d      = 1'b0;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      default: begin
        if (accept) begin
          if (isMul) begin
            valid_d = 1'b0;
            acc_d   = '0;
            mcand_d = io_a;
            mplr_d  = io_b;
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            result_d   = aluRes;
            resultHi_d = '0;
            zero_d     = (flagRes == '0);
            carry_d    = aluCarry;
            neg_d      = flagRes[WIDTH-1];
            ovf_d      = aluOvf;
            ill_d      = aluIll;
            valid_d    = 1'b1;
            state_d    = HOLD;
          end
        end else if ((state_q == HOLD) && io_out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      result_q   <= '0;
      resultHi_q <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      resultHi_q <= resultHi_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      ill_q      <= ill_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplr_q     <= mplr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign io_out_valid = valid_q;
  assign io_result    = result_q;
  assign io_result_hi = resultHi_q;
  assign io_zero      = zero_q;
  assign io_carry     = carry_q;
  assign io_negative  = neg_q;
  assign io_overflow  = ovf_q;
  assign io_illegal   = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: one instance with the multiplier, one without,
// sharing operands; expected values are hand-computed constants.
module tb_alu_pipe;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        inValidNm;
  logic        io_out_ready;
  logic [15:0] io_a;
  logic [15:0] io_b;
  logic [3:0]  io_aluOp;

  logic        io_in_ready, io_out_valid;
  logic [15:0] io_result, io_result_hi;
  logic        io_zero, io_carry, io_negative, io_overflow, io_illegal;

  logic        nmInReady, nmOutValid;
  logic [15:0] nmResult, nmResultHi;
  logic        nmZero, nmCarry, nmNegative, nmOverflow, nmIllegal;

  int testsRun  = 0;
  int failCount = 0;

  alu_pipe #(.WIDTH(16), .MUL_ENABLE(1)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_a(io_a), .io_b(io_b), .io_aluOp(io_aluOp),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_result(io_result), .io_result_hi(io_result_hi),
    .io_zero(io_zero), .io_carry(io_carry), .io_negative(io_negative),
    .io_overflow(io_overflow), .io_illegal(io_illegal)
  );

  alu_pipe #(.WIDTH(16), .MUL_ENABLE(0)) dutNoMul (
    .clock(clock), .reset(reset),
    .io_in_valid(inValidNm), .io_in_ready(nmInReady),
    .io_a(io_a), .io_b(io_b), .io_aluOp(io_aluOp),
    .io_out_valid(nmOutValid), .io_out_ready(io_out_ready),
    .io_result(nmResult), .io_result_hi(nmResultHi),
    .io_zero(nmZero), .io_carry(nmCarry), .io_negative(nmNegative),
    .io_overflow(nmOverflow), .io_illegal(nmIllegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] op,
                               input logic [15:0] a, input logic [15:0] b);
    io_in_valid = valid;
    io_aluOp    = op;
    io_a        = a;
    io_b        = b;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin : stimulus
    int legacyExp [8] = '{12, 17, 7, 4, 13, 9, 5, 6};
    int busyBad;

    reset        = 1'b1;
    inValidNm    = 1'b0;
    io_out_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0);
    #3;
    checkOutput("reset in_ready", io_in_ready, 1);
    checkOutput("reset out_valid", io_out_valid, 0);
    checkOutput("reset result", io_result, 0);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("post-reset in_ready", io_in_ready, 1);

    // Legacy opcodes back-to-back with a=12, b=5
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'(i), 16'd12, 16'd5);
      tick();
      checkOutput($sformatf("legacy op%0d result", i), io_result, legacyExp[i]);
      checkOutput($sformatf("legacy op%0d out_valid", i), io_out_valid, 1);
      checkOutput($sformatf("legacy op%0d in_ready", i), io_in_ready, 1);
    end
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0);
    tick();
    checkOutput("idle out_valid", io_out_valid, 0);

    applyStimulus(1'b1, 4'd1, 16'hFFFF, 16'h0001);
    tick();
    checkOutput("add wrap result", io_result, 16'h0000);
    checkOutput("add wrap zero", io_zero, 1);
    checkOutput("add wrap carry", io_carry, 1);
    checkOutput("add wrap overflow", io_overflow, 0);

    applyStimulus(1'b1, 4'd1, 16'h7FFF, 16'h0001);
    tick();
    checkOutput("add ovf result", io_result, 16'h8000);
    checkOutput("add ovf negative", io_negative, 1);
    checkOutput("add ovf overflow", io_overflow, 1);
    checkOutput("add ovf carry", io_carry, 0);

    applyStimulus(1'b1, 4'd2, 16'd3, 16'd5);
    tick();
    checkOutput("sub result", io_result, 16'hFFFE);
    checkOutput("sub borrow", io_carry, 1);

    applyStimulus(1'b1, 4'd9, 16'h8004, 16'd0);
    tick();
    checkOutput("sra result", io_result, 16'hC002);
    checkOutput("sra carry", io_carry, 0);

    applyStimulus(1'b1, 4'd8, 16'h8001, 16'd0);
    tick();
    checkOutput("shl result", io_result, 16'h0002);
    checkOutput("shl carry", io_carry, 1);

    applyStimulus(1'b1, 4'd13, 16'h1234, 16'd0);
    tick();
    checkOutput("reserved result", io_result, 16'h1234);
    checkOutput("reserved illegal", io_illegal, 1);

    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0);
    tick();

    // 300*500 = 150000 = 0x0002_49F0
    applyStimulus(1'b1, 4'd10, 16'd300, 16'd500);
    tick();
    checkOutput("mulu accept out_valid", io_out_valid, 0);
    checkOutput("mulu accept in_ready", io_in_ready, 0);
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0);
    busyBad = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (io_out_valid || io_in_ready) busyBad++;
    end
    checkOutput("mulu busy cycles", busyBad, 0);
    tick();
    checkOutput("mulu out_valid", io_out_valid, 1);
    checkOutput("mulu result", io_result, 16'h49F0);
    checkOutput("mulu result_hi", io_result_hi, 16'h0002);
    checkOutput("mulu carry", io_carry, 1);
    checkOutput("mulu zero", io_zero, 0);
    tick();

    inValidNm = 1'b1;
    applyStimulus(1'b0, 4'd10, 16'h0ABC, 16'd3);
    tick();
    inValidNm = 1'b0;
    checkOutput("nomul out_valid", nmOutValid, 1);
    checkOutput("nomul result", nmResult, 16'h0ABC);
    checkOutput("nomul result_hi", nmResultHi, 16'h0000);
    checkOutput("nomul illegal", nmIllegal, 1);
    tick();

    // Backpressure: result must hold while the consumer stalls
    io_out_ready = 1'b0;
    applyStimulus(1'b1, 4'd1, 16'd12, 16'd5);
    tick();
    applyStimulus(1'b1, 4'd5, 16'd12, 16'd5);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall%0d result", k), io_result, 17);
      checkOutput($sformatf("stall%0d out_valid", k), io_out_valid, 1);
      checkOutput($sformatf("stall%0d in_ready", k), io_in_ready, 0);
      tick();
    end
    io_out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", io_in_ready, 1);
    tick();
    checkOutput("queued xor result", io_result, 9);
    checkOutput("queued xor out_valid", io_out_valid, 1);
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0);
    tick();

    // Asynchronous reset in the middle of a multiply
    applyStimulus(1'b1, 4'd10, 16'd300, 16'd500);
    tick();
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0);
    repeat (8) tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async rst out_valid", io_out_valid, 0);
    checkOutput("async rst result", io_result, 0);
    checkOutput("async rst result_hi", io_result_hi, 0);
    checkOutput("async rst flags", {io_zero, io_carry, io_negative, io_overflow, io_illegal}, 0);
    checkOutput("async rst in_ready", io_in_ready, 1);
    tick();
    reset = 1'b0;
    checkOutput("after rst in_ready", io_in_ready, 1);
    applyStimulus(1'b1, 4'd4, 16'd12, 16'd5);
    tick();
    checkOutput("after rst or result", io_result, 13);
    checkOutput("after rst or out_valid", io_out_valid, 1);
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
